// File: rtl/reg_bus_pkg.sv
// Shared definitions for the register bus: bridge FSM states, rd_wr encoding
// and the register data width.
package reg_bus_pkg;

    localparam int REG_DATA_W = 32;

    localparam logic RD_WR_READ  = 1'b0;
    localparam logic RD_WR_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } bridge_state_e;

endpackage

// File: rtl/reg_apb_bridge_if.sv
// APB3 + register-block signal bundle for reg_apb_bridge.
//   slave  : bridge view (APB slave, register-block requester)
//   master : environment view (APB master, register block)
// APB:   psel, penable, pwrite, paddr, pwdata -> ; <- prdata, pready, pslverr
// Regs:  addr, rd_wr, req, write_val -> ; <- read_val, ack
interface reg_apb_bridge_if #(
    parameter int ADDR_SIZE_P = 4
);
    import reg_bus_pkg::*;

    logic                   psel;
    logic                   penable;
    logic                   pwrite;
    logic [ADDR_SIZE_P-1:0] paddr;
    logic [REG_DATA_W-1:0]  pwdata;
    logic [REG_DATA_W-1:0]  prdata;
    logic                   pready;
    logic                   pslverr;

    logic [ADDR_SIZE_P-1:0] addr;
    logic                   rd_wr;
    logic                   req;
    logic [REG_DATA_W-1:0]  write_val;
    logic [REG_DATA_W-1:0]  read_val;
    logic                   ack;

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, read_val, ack,
        output prdata, pready, pslverr, addr, rd_wr, req, write_val
    );

    modport master (
        output psel, penable, pwrite, paddr, pwdata, read_val, ack,
        input  prdata, pready, pslverr, addr, rd_wr, req, write_val
    );

endinterface

// File: rtl/reg_apb_timer.sv
// Request timeout down-counter (only used when REG_APB_TIMEOUT_EN is defined).
// Ports: clk, reset_L (async active-low), start (load TIMEOUT_P-1 and arm),
//        ack (completes the request, disarms), expired (count reached 0 with no ack).
module reg_apb_timer #(
    parameter int TIMEOUT_P = 16
) (
    input  logic clk,
    input  logic reset_L,
    input  logic start,
    input  logic ack,
    output logic expired
);

    localparam int               CNT_W  = (TIMEOUT_P > 1) ? $clog2(TIMEOUT_P) : 1;
    localparam logic [CNT_W-1:0] LOAD_V = CNT_W'(TIMEOUT_P - 1);

    logic [CNT_W-1:0] cnt;
    logic             running;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            cnt     <= LOAD_V;
            running <= 1'b1;
        end else if (running) begin
            if (ack || (cnt == '0)) begin
                running <= 1'b0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // ack in the terminal cycle wins over the timeout.
    assign expired = running && (cnt == '0) && !ack;

endmodule

// File: rtl/reg_apb_bridge.sv
// APB3 slave front-end turning each APB transfer into one req/ack register access.
// Ports: clk, reset_L (async active-low), bus (reg_apb_bridge_if.slave: APB side
//        psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr, register side
//        addr/rd_wr/req/write_val/read_val/ack).
// Build option: REG_APB_TIMEOUT_EN adds a TIMEOUT_P-cycle request timeout that
//        completes the transfer with pslverr=1; without it pslverr is tied 0.
//
// state | meaning
// IDLE  | waiting for an APB setup phase
// REQ   | req high, waiting for ack (or timeout)
// DONE  | access finished; pready/pslverr/prdata present next cycle
module reg_apb_bridge
    import reg_bus_pkg::*;
#(
    parameter int ADDR_SIZE_P = 4,
    parameter int TIMEOUT_P   = 16
) (
    input  logic             clk,
    input  logic             reset_L,
    reg_apb_bridge_if.slave  bus
);

    bridge_state_e state, state_nxt;

    logic                   setup;
    logic                   load;
    logic                   capture;
    logic [ADDR_SIZE_P-1:0] addr_q;
    logic                   rd_wr_q;
    logic [REG_DATA_W-1:0]  write_val_q;
    logic [REG_DATA_W-1:0]  prdata_q;
    logic                   pready_q;

    assign setup = bus.psel && !bus.penable;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef REG_APB_TIMEOUT_EN
    logic expired;
    logic err_set;
    logic err_q;
    logic pslverr_q;
`endif

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        capture   = 1'b0;
`ifdef REG_APB_TIMEOUT_EN
        err_set   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (setup) begin
                    state_nxt = REQ;
                    load      = 1'b1;
                end
            end
            REQ: begin
                if (bus.ack) begin
                    state_nxt = DONE;
                    capture   = (rd_wr_q == RD_WR_READ);
                end
`ifdef REG_APB_TIMEOUT_EN
                else if (expired) begin
                    state_nxt = DONE;
                    err_set   = 1'b1;
                end
`endif
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // pready is registered off DONE, so it appears the cycle after DONE while
    // the FSM is already back in IDLE; this gives the 3-cycle minimum wait.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            addr_q      <= '0;
            rd_wr_q     <= RD_WR_READ;
            write_val_q <= '0;
            prdata_q    <= '0;
            pready_q    <= 1'b0;
        end else begin
            if (load) begin
                addr_q  <= bus.paddr;
                rd_wr_q <= bus.pwrite;
                if (bus.pwrite == RD_WR_WRITE) begin
                    write_val_q <= bus.pwdata;
                end
            end
            if (capture) begin
                prdata_q <= bus.read_val;
            end
            pready_q <= (state == DONE);
        end
    end

`ifdef REG_APB_TIMEOUT_EN
    reg_apb_timer #(
        .TIMEOUT_P (TIMEOUT_P)
    ) u_timer (
        .clk     (clk),
        .reset_L (reset_L),
        .start   (load),
        .ack     (bus.ack),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            err_q     <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            if (state == REQ) begin
                err_q <= err_set;
            end
            pslverr_q <= (state == DONE) && err_q;
        end
    end

    assign bus.pslverr = pslverr_q;
`else
    assign bus.pslverr = 1'b0;
`endif

    // req comes straight from the state register so reset drops it asynchronously.
    assign bus.req       = (state == REQ);
    assign bus.addr      = addr_q;
    assign bus.rd_wr     = rd_wr_q;
    assign bus.write_val = write_val_q;
    assign bus.prdata    = prdata_q;
    assign bus.pready    = pready_q;

endmodule
